spi_cmd_scheduler: RTL and testbench

- Shares one SPI register-access driver (read and write engines) between NUM_REQ requesters, e.g. host bridge and housekeeping poller.
- Arbitrates round-robin, launches one command at a time with correct new_command edge spacing, and routes read-back bytes to the owning requester, tagged with its ID.
- Adds a watchdog timeout and rejects malformed commands.

---
 rtl/spi_ctrl_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/spi_cmd_scheduler.sv | 132 +++++++++++++
 tb/tb_spi_cmd_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state type and sizing helpers for the SPI command scheduler.
package spi_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, GAP} sched_state_t;
  localparam int TO_W = 16;
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping.
module rr_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  logic [IW-1:0] k;
  always_comb begin
    grant_idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) grant_idx = k;
    end
    any = |req;
    grant = any ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: shares one SPI register driver between requesters round-robin,
// routing read bytes to the owner, with watchdog timeout and zero-length rejection.
module spi_cmd_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int REG_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_is_write,
  input  logic [NUM_REQ*REG_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]         req_num_regs,
  output logic                         drv_new_command,
  output logic                         drv_is_write,
  output logic [REG_WIDTH-1:0]         drv_addr,
  output logic [7:0]                   drv_num_regs,
  input  logic                         drv_rd_byte_valid,
  input  logic [REG_WIDTH-1:0]         drv_rd_data,
  input  logic                         drv_rd_complete,
  input  logic                         drv_wr_complete,
  output logic                         rsp_valid,
  output logic [REG_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         rsp_last,
  output logic                         cmd_done,
  output logic                         cmd_error,
  output logic                         busy
);
  sched_state_t state;
  logic [ID_W-1:0] rr_ptr, g_idx;
  logic [NUM_REQ-1:0] grant;
  logic any_req, g_write, end_evt, take_byte;
  logic [REG_WIDTH-1:0] g_addr;
  logic [7:0] g_num, byte_cnt;
  logic [TO_W-1:0] to_cnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .grant(grant), .grant_idx(g_idx), .any(any_req)
  );

  always_comb begin
    g_write = 1'b0;
    g_addr = '0;
    g_num = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        g_write = req_is_write[i];
        g_addr = req_addr[i*REG_WIDTH +: REG_WIDTH];
        g_num = req_num_regs[i*8 +: 8];
      end
  end

  assign req_ready = (state == ARB) ? grant : '0;
  assign end_evt = drv_is_write ? drv_wr_complete : drv_rd_complete;
  assign take_byte = drv_rd_byte_valid && !drv_is_write && (byte_cnt < drv_num_regs);

  // drv_* double as the command capture, so they hold steady until the next grant
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      rr_ptr <= '0;
      drv_new_command <= 1'b0;
      drv_is_write <= 1'b0;
      drv_addr <= '0;
      drv_num_regs <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      rsp_last <= 1'b0;
      cmd_done <= 1'b0;
      cmd_error <= 1'b0;
      busy <= 1'b0;
      byte_cnt <= '0;
      to_cnt <= '0;
    end else begin
      drv_new_command <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last <= 1'b0;
      cmd_done <= 1'b0;
      cmd_error <= 1'b0;
      case (state)
        IDLE: begin
          busy <= any_req;
          state <= any_req ? ARB : IDLE;
        end
        ARB:
          if (!any_req) begin
            busy <= 1'b0;
            state <= IDLE;
          end else begin
            drv_is_write <= g_write;
            drv_addr <= g_addr;
            drv_num_regs <= g_num;
            rsp_id <= g_idx;
            rr_ptr <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
            state <= (g_num == '0) ? GAP : ISSUE;
            drv_new_command <= g_num != '0;
            cmd_done <= g_num == '0;
            cmd_error <= g_num == '0;
          end
        ISSUE: begin
          byte_cnt <= '0;
          to_cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          to_cnt <= &to_cnt ? to_cnt : to_cnt + 1'b1;
          if (take_byte) begin
            rsp_valid <= 1'b1;
            rsp_data <= drv_rd_data;
            rsp_last <= (byte_cnt + 8'd1) == drv_num_regs;
            byte_cnt <= byte_cnt + 8'd1;
          end
          if (end_evt || to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            cmd_done <= 1'b1;
            cmd_error <= !end_evt;
            state <= GAP;
          end
        end
        GAP: begin
          busy <= any_req;
          state <= any_req ? ARB : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// tb_spi_cmd_scheduler: directed scenario tests for spi_cmd_scheduler with TIMEOUT_CYCLES=20.
module tb_spi_cmd_scheduler;
  logic clk = 1'b0, rstn = 1'b0;
  logic [1:0] req_valid = '0, req_ready, req_is_write = '0;
  logic [15:0] req_addr = '0, req_num_regs = '0;
  logic drv_new_command, drv_is_write, drv_rd_byte_valid = 1'b0, drv_rd_complete = 1'b0, drv_wr_complete = 1'b0;
  logic [7:0] drv_addr, drv_num_regs, drv_rd_data = '0, rsp_data;
  logic rsp_valid, rsp_last, cmd_done, cmd_error, busy;
  logic [0:0] rsp_id;
  int checks = 0, errors = 0;
  int n_cmd = 0, n_done = 0, n_rsp = 0, n_adj = 0;
  logic prev_nc = 1'b0;

  spi_cmd_scheduler #(.NUM_REQ(2), .REG_WIDTH(8), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_num_regs(req_num_regs), .drv_new_command(drv_new_command),
    .drv_is_write(drv_is_write), .drv_addr(drv_addr), .drv_num_regs(drv_num_regs),
    .drv_rd_byte_valid(drv_rd_byte_valid), .drv_rd_data(drv_rd_data), .drv_rd_complete(drv_rd_complete),
    .drv_wr_complete(drv_wr_complete), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_last(rsp_last), .cmd_done(cmd_done), .cmd_error(cmd_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (drv_new_command) n_cmd++;
    if (cmd_done) n_done++;
    if (rsp_valid) n_rsp++;
    if (drv_new_command && prev_nc) n_adj++;
    prev_nc = drv_new_command;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [7:0] a, input logic [7:0] n);
    req_valid[i] = v;
    req_is_write[i] = w;
    req_addr[i*8 +: 8] = a;
    req_num_regs[i*8 +: 8] = n;
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({req_ready, drv_new_command, drv_is_write, drv_addr, drv_num_regs, rsp_valid, rsp_data, rsp_id,
         rsp_last, cmd_done, cmd_error, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero, busy=%b drv_addr=%h", busy, drv_addr);
    end
    rstn = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_read;
    int c0, r0, d0;
    logic [7:0] bytes [3] = '{8'hA1, 8'hB2, 8'hC3};
    c0 = n_cmd; r0 = n_rsp; d0 = n_done;
    set_req(0, 1, 0, 8'h10, 8'd3);
    tick();
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick();
    set_req(0, 0, 0, 8'h00, 8'd0);
    checks++;
    if ({drv_new_command, drv_is_write, drv_addr, drv_num_regs, busy} !== {1'b1, 1'b0, 8'h10, 8'd3, 1'b1}) begin
      errors++;
      $display("FAIL single_issue: got nc=%b w=%b a=%h n=%0d busy=%b want 1 0 10 3 1",
               drv_new_command, drv_is_write, drv_addr, drv_num_regs, busy);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drv_rd_byte_valid = 1'b1;
      drv_rd_data = bytes[i];
      tick();
      checks++;
      if ({rsp_valid, rsp_data, rsp_id, rsp_last, cmd_done} !== {1'b1, bytes[i], 1'b0, i == 2, 1'b0}) begin
        errors++;
        $display("FAIL single_byte%0d: got v=%b d=%h id=%b last=%b done=%b want 1 %h 0 %b 0",
                 i, rsp_valid, rsp_data, rsp_id, rsp_last, cmd_done, bytes[i], i == 2);
      end
    end
    drv_rd_byte_valid = 1'b0;
    drv_rd_complete = 1'b1;
    tick();
    drv_rd_complete = 1'b0;
    checks++;
    if ({cmd_done, cmd_error, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL single_done: got done=%b err=%b v=%b want 1 0 0", cmd_done, cmd_error, rsp_valid);
    end
    tick(2);
    checks++;
    if ({n_cmd - c0, n_rsp - r0, n_done - d0} !== {32'd1, 32'd3, 32'd1}) begin
      errors++;
      $display("FAIL single_counts: got cmd=%0d rsp=%0d done=%0d want 1 3 1", n_cmd - c0, n_rsp - r0, n_done - d0);
    end
  endtask

  task automatic test_zero_len;
    int c0;
    c0 = n_cmd;
    set_req(1, 1, 0, 8'h77, 8'd0);
    tick();
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_ready: got %b want 10", req_ready); end
    tick();
    set_req(1, 0, 0, 8'h00, 8'd0);
    checks++;
    if ({cmd_done, cmd_error, drv_new_command} !== 3'b110) begin
      errors++;
      $display("FAIL zero_done: got done=%b err=%b nc=%b want 1 1 0", cmd_done, cmd_error, drv_new_command);
    end
    tick(3);
    checks++;
    if (n_cmd != c0) begin errors++; $display("FAIL zero_no_cmd: got %0d strobes want 0", n_cmd - c0); end
  endtask

  task automatic test_contention;
    int c0, d0;
    bit ok;
    c0 = n_cmd; d0 = n_done;
    set_req(0, 1, 1, 8'h20, 8'd1);
    set_req(1, 1, 1, 8'h30, 8'd1);
    for (int k = 0; k < 8; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        tick();
        ok = drv_new_command;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL cont_timeout: no command %0d", k); break; end
      checks++;
      if ({drv_addr, rsp_id, drv_is_write} !== {(k % 2) ? 8'h30 : 8'h20, 1'(k % 2), 1'b1}) begin
        errors++;
        $display("FAIL cont_grant%0d: got a=%h id=%b w=%b want %h %0d 1", k, drv_addr, rsp_id, drv_is_write,
                 (k % 2) ? 8'h30 : 8'h20, k % 2);
      end
      tick();
      if (k == 0) begin
        drv_rd_complete = 1'b1;
        tick();
        drv_rd_complete = 1'b0;
        tick();
        checks++;
        if (cmd_done !== 1'b0) begin errors++; $display("FAIL cont_wrong_type: got done=%b want 0", cmd_done); end
      end
      drv_wr_complete = 1'b1;
      tick();
      drv_wr_complete = 1'b0;
      if (k == 7) begin
        set_req(0, 0, 0, 8'h00, 8'd0);
        set_req(1, 0, 0, 8'h00, 8'd0);
      end
      checks++;
      if ({cmd_done, cmd_error} !== 2'b10) begin
        errors++;
        $display("FAIL cont_done%0d: got done=%b err=%b want 1 0", k, cmd_done, cmd_error);
      end
    end
    tick(3);
    checks++;
    if ({n_cmd - c0, n_done - d0, busy} !== {32'd8, 32'd8, 1'b0}) begin
      errors++;
      $display("FAIL cont_counts: got cmd=%0d done=%0d busy=%b want 8 8 0", n_cmd - c0, n_done - d0, busy);
    end
  endtask

  task automatic test_timeout;
    int d0, r0, lat;
    set_req(0, 1, 0, 8'h40, 8'd2);
    tick(2);
    set_req(0, 0, 0, 8'h00, 8'd0);
    checks++;
    if (drv_new_command !== 1'b1) begin errors++; $display("FAIL to_issue: got nc=%b want 1", drv_new_command); end
    d0 = n_done; r0 = n_rsp; lat = 0;
    // ISSUE is cycle 0, then 20 WAIT cycles, so the abort shows in cycle 21
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cmd_done) begin lat = i; break; end
    end
    checks++;
    if ({lat, cmd_error} !== {32'd21, 1'b1}) begin
      errors++;
      $display("FAIL to_latency: got lat=%0d err=%b want 21 1", lat, cmd_error);
    end
    drv_rd_byte_valid = 1'b1;
    drv_rd_complete = 1'b1;
    tick(2);
    drv_rd_byte_valid = 1'b0;
    drv_rd_complete = 1'b0;
    tick(2);
    checks++;
    if ({n_done - d0, n_rsp - r0} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL to_late_ignored: got done=%0d rsp=%0d want 1 0", n_done - d0, n_rsp - r0);
    end
    set_req(1, 1, 1, 8'h50, 8'd1);
    tick(2);
    set_req(1, 0, 0, 8'h00, 8'd0);
    checks++;
    if ({drv_new_command, drv_addr, drv_is_write} !== {1'b1, 8'h50, 1'b1}) begin
      errors++;
      $display("FAIL to_next_issue: got nc=%b a=%h w=%b want 1 50 1", drv_new_command, drv_addr, drv_is_write);
    end
    tick();
    drv_wr_complete = 1'b1;
    tick();
    drv_wr_complete = 1'b0;
    checks++;
    if ({cmd_done, cmd_error} !== 2'b10) begin
      errors++;
      $display("FAIL to_next_done: got done=%b err=%b want 1 0", cmd_done, cmd_error);
    end
    tick(2);
  endtask

  task automatic test_same_cycle;
    int r0;
    set_req(0, 1, 0, 8'h60, 8'd3);
    tick(2);
    set_req(0, 0, 0, 8'h00, 8'd0);
    tick();
    drv_rd_byte_valid = 1'b1;
    drv_rd_data = 8'h11;
    tick();
    drv_rd_data = 8'h22;
    tick();
    drv_rd_data = 8'h33;
    drv_rd_complete = 1'b1;
    tick();
    drv_rd_byte_valid = 1'b0;
    drv_rd_complete = 1'b0;
    checks++;
    if ({rsp_valid, rsp_last, rsp_data, cmd_done, cmd_error} !== {1'b1, 1'b1, 8'h33, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL same_cycle_end: got v=%b last=%b d=%h done=%b err=%b want 1 1 33 1 0",
               rsp_valid, rsp_last, rsp_data, cmd_done, cmd_error);
    end
    tick(2);
    r0 = n_rsp;
    set_req(0, 1, 0, 8'h68, 8'd3);
    tick(2);
    set_req(0, 0, 0, 8'h00, 8'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv_rd_byte_valid = 1'b1;
      drv_rd_data = 8'(8'hD0 + i);
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL extra_byte_dropped: got v=%b want 0", rsp_valid); end
    drv_rd_byte_valid = 1'b0;
    drv_rd_complete = 1'b1;
    tick();
    drv_rd_complete = 1'b0;
    checks++;
    if ({cmd_done, cmd_error, n_rsp - r0} !== {1'b1, 1'b0, 32'd3}) begin
      errors++;
      $display("FAIL extra_done: got done=%b err=%b rsp=%0d want 1 0 3", cmd_done, cmd_error, n_rsp - r0);
    end
    tick(2);
  endtask

  task automatic test_reset_mid;
    int d0;
    set_req(0, 1, 0, 8'h70, 8'd4);
    tick(2);
    set_req(0, 0, 0, 8'h00, 8'd0);
    tick();
    drv_rd_byte_valid = 1'b1;
    drv_rd_data = 8'h5A;
    tick();
    drv_rd_byte_valid = 1'b0;
    d0 = n_done;
    rstn = 1'b0;
    #1;
    checks++;
    if ({req_ready, drv_new_command, drv_is_write, drv_addr, drv_num_regs, rsp_valid, rsp_data, rsp_id,
         rsp_last, cmd_done, cmd_error, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b v=%b d=%h a=%h", busy, rsp_valid, rsp_data, drv_addr);
    end
    tick(2);
    rstn = 1'b1;
    drv_rd_complete = 1'b1;
    tick();
    drv_rd_complete = 1'b0;
    tick(2);
    checks++;
    if ({n_done - d0, busy} !== {32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_no_done: got done=%0d busy=%b want 0 0", n_done - d0, busy);
    end
    set_req(0, 1, 1, 8'h01, 8'd1);
    set_req(1, 1, 1, 8'h02, 8'd1);
    tick();
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_mid_ptr: got %b want 01", req_ready); end
    set_req(0, 0, 0, 8'h00, 8'd0);
    set_req(1, 0, 0, 8'h00, 8'd0);
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_zero_len();
    test_contention();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    checks++;
    if (n_adj != 0) begin errors++; $display("FAIL strobe_spacing: got %0d adjacent strobes want 0", n_adj); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
